mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported Memoria between two requesters: the multicycle CPU datapath (port "cpu", via MuxPc address and Wr control) and a program/debug loader (port "ldr").
- Sequences each access through the memory's fixed read latency.
- Returns the read data with a one-cycle acknowledge.
- CPU has priority; a starvation counter guarantees loader progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from address presentation to valid mem_rdata (≥1)
- MAX_WAIT, 4, consecutive CPU grants while ldr_req is pending before the loader is forced (≥1)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1
- ldr_req, ldr_wr, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: same meanings and widths, loader side
- mem_addr  out  ADDR_W  to Memoria Address
- mem_wr  out  1  to Memoria Wr
- mem_wdata  out  DATA_W  to Memoria write data
- mem_rdata  in  DATA_W  from Memoria Dataout
- busy  out  1  1 while state ≠ IDLE
- owner  out  1  0 = CPU, 1 = loader; last granted requester

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, starve=0, owner=0.
  - All outputs 0, including latched addr/wdata/rdata registers.
- Reset asserted mid-transaction aborts it: no ack is issued and the memory write is not repeated.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples cpu_req and ldr_req.
  - If any request is present: grant, latch the winner's wr/addr/wdata into internal registers, set owner, load the latency counter with MEM_LAT-1, and go to ACCESS.
  - If no request: stay in IDLE.
- Arbitration:
  - Only one request present: that requester wins.
  - Both present: CPU wins unless starve==MAX_WAIT, in which case the loader wins.
  - starve increments when the CPU is granted while ldr_req=1, saturating at MAX_WAIT.
  - starve clears to 0 when the loader is granted, or in any IDLE cycle with ldr_req=0.
- ACCESS:
  - Lasts exactly MEM_LAT cycles.
  - mem_addr = latched addr and mem_wdata = latched wdata for the whole state.
  - mem_wr = latched wr only in the first ACCESS cycle; 0 afterwards, so there is exactly one write strobe per access.
  - In the last ACCESS cycle (counter==0), mem_rdata is captured into the rdata register on reads; on writes the register holds its previous value.
  - Then go to DONE.
- DONE:
  - Exactly one cycle. The owner's ack=1; the owner's rdata output shows the captured word on reads, and is don't-care on writes.
  - The other ack is 0.
  - Requests are not sampled in DONE.
  - Next state is IDLE.
- Outside ACCESS: mem_addr, mem_wdata, mem_wr = 0.
- Latency: a request seen in IDLE at edge N gives ack high during cycle N+MEM_LAT+1. Minimum spacing between accesses is MEM_LAT+2 cycles.
- Handshake rules:
  - A requester drops req on the edge that ends its ack cycle.
  - req still high in the following IDLE cycle is a new request.
  - req or inputs changing after grant are ignored, because inputs are latched at grant.
  - req dropped before ack does not cancel the access; the ack still pulses.
- Simultaneous events:
  - Both requests arriving in the same cycle: resolved by the arbitration rules above.
  - The loser is not queued separately; it keeps its req high and is served in a later IDLE cycle.
- Counters: the latency counter is ceil(log2(MEM_LAT))+1 bits wide and never wraps. starve saturates at MAX_WAIT and never wraps.

Test Plan:
- Reset=0 during ACCESS of a write at addr 0x10 → all outputs 0 immediately (asynchronous); after release, no ack and no second mem_wr pulse.
- CPU read, cpu_addr=0x40, memory model returns 0xDEADBEEF after 2 cycles → mem_addr=0x40 for 2 cycles, mem_wr=0, cpu_ack high in cycle 3 after grant with cpu_rdata=0xDEADBEEF, busy=1 for 3 cycles.
- Loader write, ldr_addr=0x8, ldr_wdata=0x12345678 → mem_wr high exactly 1 cycle with those values, ldr_ack 1 cycle, owner=1, cpu_ack stays 0.
- cpu_req and ldr_req held continuously (MAX_WAIT=4) → grant sequence CPU, CPU, CPU, CPU, LDR, CPU…; starve returns to 0 after the loader grant.
- cpu_addr changed from 0x40 to 0x80 and cpu_req dropped during ACCESS → mem_addr stays 0x40, cpu_ack still pulses once.
- cpu_req held high through the cycle after ack → a second access starts in that IDLE cycle with no idle gap beyond that single IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester and memory-side signal bundle for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ldr_req;
    logic              ldr_wr;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_ack;
    logic [DATA_W-1:0] ldr_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_wr, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
        output mem_addr, mem_wr, mem_wdata, busy, owner
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output ldr_req, ldr_wr, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
        input  mem_addr, mem_wr, mem_wdata, busy, owner
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester arbiter (CPU priority, loader anti-starvation)
//               for a single-ported fixed-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W    = $clog2(MEM_LAT) + 1;
    localparam int STARVE_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(MEM_LAT - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [STARVE_W-1:0] r_starve;
    logic                r_owner;
    logic                r_busy;
    logic                r_wr;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_cpu_ack;
    logic                r_ldr_ack;

    logic w_ldr_win;

    // Loader wins when alone, or when it has waited out MAX_WAIT CPU grants.
    assign w_ldr_win = bus.ldr_req && (!bus.cpu_req || (r_starve == STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_owner     <= 1'b0;
            r_busy      <= 1'b0;
            r_wr        <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_cpu_ack   <= 1'b0;
            r_ldr_ack   <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_ldr_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!bus.ldr_req) begin
                        r_starve <= '0;
                    end
                    if (bus.cpu_req || bus.ldr_req) begin
                        r_state <= ACCESS;
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_INIT;
                        if (w_ldr_win) begin
                            r_owner     <= 1'b1;
                            r_wr        <= bus.ldr_wr;
                            r_mem_wr    <= bus.ldr_wr;
                            r_mem_addr  <= bus.ldr_addr;
                            r_mem_wdata <= bus.ldr_wdata;
                            r_starve    <= '0;
                        end else begin
                            r_owner     <= 1'b0;
                            r_wr        <= bus.cpu_wr;
                            r_mem_wr    <= bus.cpu_wr;
                            r_mem_addr  <= bus.cpu_addr;
                            r_mem_wdata <= bus.cpu_wdata;
                            if (bus.ldr_req && (r_starve != STARVE_MAX)) begin
                                r_starve <= r_starve + 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    // Single write strobe: only the first ACCESS cycle drives mem_wr.
                    r_mem_wr <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state     <= DONE;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        if (!r_wr) begin
                            r_rdata <= bus.mem_rdata;
                        end
                        if (r_owner) begin
                            r_ldr_ack <= 1'b1;
                        end else begin
                            r_cpu_ack <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.ldr_ack   = r_ldr_ack;
    assign bus.cpu_rdata = r_rdata;
    assign bus.ldr_rdata = r_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a 2-cycle memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;
    int   n_ack;
    int   n_wr;
    int   cyc;

    typedef struct packed {
        logic        who;
        logic        wr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_WAIT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data for an address appears MEM_LAT=2 cycles after it is presented.
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        rd_q <= mem[bus.mem_addr[7:0]];
    end
    assign bus.mem_rdata = rd_q;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic who, input logic wr, input logic [31:0] d);
        exp_t e;
        e.who = who; e.wr = wr; e.rdata = d;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.mem_wr) n_wr++;
        if (bus.cpu_ack || bus.ldr_ack) begin
            exp_t e;
            n_ack++;
            chk("ack_onehot", {bus.cpu_ack, bus.ldr_ack} == 2'b11, 0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("ack_who", bus.ldr_ack, e.who);
                chk("ack_owner", bus.owner, e.who);
                if (!e.wr) chk("ack_rdata", e.who ? bus.ldr_rdata : bus.cpu_rdata, e.rdata);
            end
        end
    end

    task automatic wait_ack(output int at);
        logic got;
        got = 1'b0;
        at  = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.ldr_ack) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    initial begin
        int a0, w0, t1, t2;
        n_chk = 0; n_bad = 0; n_ack = 0; n_wr = 0; cyc = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'hDEADBEEF;
        mem[8'h80] = 32'h0BADF00D;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.ldr_req = 0; bus.ldr_wr = 0; bus.ldr_addr = 0; bus.ldr_wdata = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_acks", {bus.cpu_ack, bus.ldr_ack}, 0);
        chk("rst_mem", {bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU read of 0x40
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 32'h40;
        push(0, 0, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_c1", {bus.busy, bus.mem_wr, bus.mem_addr}, {1'b1, 1'b0, 32'h40});
        @(negedge clk);
        chk("rd_c2", {bus.busy, bus.mem_wr, bus.mem_addr}, {1'b1, 1'b0, 32'h40});
        @(negedge clk);
        chk("rd_c3", {bus.busy, bus.cpu_ack, bus.mem_addr}, {1'b1, 1'b1, 32'h0});
        bus.cpu_req = 0;
        @(negedge clk);
        chk("rd_idle", bus.busy, 0);

        // Loader write 0x8 <- 0x12345678
        w0 = n_wr;
        bus.ldr_req = 1; bus.ldr_wr = 1; bus.ldr_addr = 32'h8; bus.ldr_wdata = 32'h12345678;
        push(1, 1, 32'h0);
        @(negedge clk);
        chk("wr_c1", {bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.owner}, {1'b1, 32'h8, 32'h12345678, 1'b1});
        @(negedge clk);
        chk("wr_c2", {bus.mem_wr, bus.mem_wdata}, {1'b0, 32'h12345678});
        @(negedge clk);
        chk("wr_c3", {bus.ldr_ack, bus.cpu_ack}, 2'b10);
        bus.ldr_req = 0;
        chk("wr_pulses", n_wr - w0, 1);
        @(negedge clk);

        // Contention: both requests held, expect CPU x4 then loader, twice
        bus.ldr_wr = 0;
        bus.cpu_req = 1; bus.cpu_addr = 32'h40;
        bus.ldr_req = 1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) push(0, 0, 32'hDEADBEEF);
            push(1, 0, 32'h12345678);
        end
        for (int i = 0; i < 10; i++) wait_ack(t1);
        bus.cpu_req = 0; bus.ldr_req = 0;
        repeat (2) @(negedge clk);

        // Inputs changed and req dropped after grant
        a0 = n_ack;
        bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 32'h40;
        push(0, 0, 32'hDEADBEEF);
        @(negedge clk);
        bus.cpu_addr = 32'h80; bus.cpu_req = 0;
        @(negedge clk);
        chk("latched_addr", bus.mem_addr, 32'h40);
        wait_ack(t1);
        repeat (6) @(negedge clk);
        chk("single_ack", n_ack - a0, 1);

        // Back-to-back: req held through the IDLE cycle after ack
        bus.cpu_req = 1; bus.cpu_addr = 32'h8;
        push(0, 0, 32'h12345678);
        push(0, 0, 32'h12345678);
        wait_ack(t1);
        wait_ack(t2);
        bus.cpu_req = 0;
        chk("b2b_spacing", t2 - t1, 4);
        repeat (2) @(negedge clk);

        // Asynchronous reset during ACCESS of a write to 0x10
        bus.cpu_req = 1; bus.cpu_wr = 1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("abort_wr_seen", bus.mem_wr, 1);
        #2;
        rst_n = 1'b0;
        bus.cpu_req = 0;
        #1;
        chk("abort_mem", {bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 0);
        chk("abort_state", {bus.busy, bus.owner, bus.cpu_ack, bus.ldr_ack}, 0);
        chk("abort_rdata", bus.cpu_rdata, 0);
        w0 = n_wr; a0 = n_ack;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_wr", n_wr - w0, 0);
        chk("abort_no_ack", n_ack - a0, 0);
        chk("abort_mem_untouched", mem[8'h10], 32'h0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
